// File: rtl/csi_dbg_pkg.sv
// Shared definitions for the CSI-2 statistics monitor.
// Holds the frame/line tracker state encoding, the stat_sel index values
// and the default identification byte returned by the readout.
package csi_dbg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FRAME = 2'd1,
    ST_LINE  = 2'd2
  } state_t;

  localparam logic [2:0] STAT_GOOD  = 3'd0;
  localparam logic [2:0] STAT_ERR   = 3'd1;
  localparam logic [2:0] STAT_FRAME = 3'd2;
  localparam logic [2:0] STAT_LINES = 3'd3;
  localparam logic [2:0] STAT_WORDS = 3'd4;
  localparam logic [2:0] STAT_MAXW  = 3'd5;
  localparam logic [2:0] STAT_VIOL  = 3'd6;
  localparam logic [2:0] STAT_ID    = 3'd7;

  localparam logic [7:0] DEFAULT_ID_BYTE = 8'hC5;

endpackage

// File: rtl/csi_sat_counter.sv
// Saturating up-counter.
// Ports:
//   csi_byte_clk  clock
//   reset         asynchronous, active-high
//   clr           synchronous clear; together with inc it loads 1
//   inc           increment by one, held at all-ones once saturated
//   count         current value
module csi_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             csi_byte_clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // NOTE: sequential state is always assigned with <= so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge csi_byte_clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= inc ? ONE : '0;
    end else if (inc && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/csi_stat_monitor.sv
// CSI-2 receive statistics and debug monitor.
// Tracks frame/line geometry, packet checksum results and protocol
// violations in saturating counters, and serves one byte of a selected
// statistic on dbg_byte for debug pins.
// Ports:
//   csi_byte_clk, reset       clock, asynchronous active-high reset
//   enable                    monitor enable; low forces IDLE and freezes counts
//   clear                     synchronous clear of counters and err_seen
//   frame_start, frame_end    single-cycle frame delimiters
//   raw_valid                 pixel word valid; a contiguous high run is a line
//   pkt_good, pkt_err         packet checksum result pulses
//   stat_sel, byte_sel        readout select (statistic, byte lane)
//   dbg_byte                  registered readout byte
//   err_seen                  sticky checksum error / protocol violation flag
//   frame_active              high while inside a frame
module csi_stat_monitor
  import csi_dbg_pkg::*;
#(
  parameter int         CNT_W      = 16,
  parameter int         BYTE_SEL_W = 1,
  parameter logic [7:0] ID_BYTE    = DEFAULT_ID_BYTE
) (
  input  logic                  csi_byte_clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  clear,
  input  logic                  frame_start,
  input  logic                  frame_end,
  input  logic                  raw_valid,
  input  logic                  pkt_good,
  input  logic                  pkt_err,
  input  logic [2:0]            stat_sel,
  input  logic [BYTE_SEL_W-1:0] byte_sel,
  output logic [7:0]            dbg_byte,
  output logic                  err_seen,
  output logic                  frame_active
);

  localparam logic [BYTE_SEL_W:0] NUM_BYTES = (BYTE_SEL_W + 1)'(CNT_W / 8);

  state_t state, state_n;
  logic   run_en, raw_valid_q, raw_rise, in_line;
  logic   line_clr, line_inc, word_load, word_inc, max_clr;
  logic   line_close, frame_close, viol;

  logic [CNT_W-1:0] good_cnt, err_cnt, frame_cnt, viol_cnt, line_cnt, word_cnt;
  logic [CNT_W-1:0] lines_last, words_last, max_words, run_max, close_max;
  logic [CNT_W-1:0] sel_stat, shifted;
  logic [7:0]       rd_byte;

  assign run_en    = enable && !clear;
  assign raw_rise  = raw_valid && !raw_valid_q;
  assign in_line   = (state == ST_LINE);
  assign close_max = (word_cnt > run_max) ? word_cnt : run_max;
  assign frame_active = (state != ST_IDLE);

  // NOTE: every signal driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_n     = state;
    line_clr    = 1'b0;
    line_inc    = 1'b0;
    word_load   = 1'b0;
    word_inc    = 1'b0;
    max_clr     = 1'b0;
    line_close  = 1'b0;
    frame_close = 1'b0;
    viol        = 1'b0;
    if (!run_en) begin
      state_n = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (frame_start) begin
            state_n  = ST_FRAME;
            line_clr = 1'b1;
            max_clr  = 1'b1;
          end else if (frame_end || raw_rise) begin
            viol = 1'b1;
          end
        end
        ST_FRAME, ST_LINE: begin
          // frame_end is handled before frame_start, so a coincident pair
          // closes this frame and opens a fresh one without a violation.
          if (frame_end) begin
            line_close  = in_line;
            frame_close = 1'b1;
            state_n     = ST_IDLE;
          end else if (frame_start) begin
            viol = 1'b1;
          end
          if (frame_start) begin
            state_n  = ST_FRAME;
            line_clr = 1'b1;
            max_clr  = 1'b1;
          end else if (!frame_end) begin
            if (!in_line) begin
              if (raw_valid) begin
                state_n   = ST_LINE;
                line_inc  = 1'b1;
                word_load = 1'b1;
              end
            end else if (raw_valid) begin
              word_inc = 1'b1;
            end else begin
              state_n    = ST_FRAME;
              line_close = 1'b1;
            end
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge csi_byte_clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      raw_valid_q <= 1'b0;
      err_seen    <= 1'b0;
      dbg_byte    <= '0;
    end else begin
      state       <= state_n;
      raw_valid_q <= raw_valid;
      dbg_byte    <= rd_byte;
      if (clear) begin
        err_seen <= 1'b0;
      end else if (run_en && (pkt_err || viol)) begin
        err_seen <= 1'b1;
      end
    end
  end

  // Latched geometry of the last completed line/frame and the running max.
  always_ff @(posedge csi_byte_clk or posedge reset) begin
    if (reset) begin
      lines_last <= '0;
      words_last <= '0;
      max_words  <= '0;
      run_max    <= '0;
    end else if (clear) begin
      lines_last <= '0;
      words_last <= '0;
      max_words  <= '0;
      run_max    <= '0;
    end else begin
      if (line_close) words_last <= word_cnt;
      if (frame_close) begin
        lines_last <= line_cnt;
        max_words  <= in_line ? close_max : run_max;
      end
      if (max_clr) begin
        run_max <= '0;
      end else if (line_close) begin
        run_max <= close_max;
      end
    end
  end

  csi_sat_counter #(.CNT_W(CNT_W)) u_good (
    .csi_byte_clk(csi_byte_clk), .reset(reset), .clr(clear),
    .inc(run_en && pkt_good), .count(good_cnt));
  csi_sat_counter #(.CNT_W(CNT_W)) u_err (
    .csi_byte_clk(csi_byte_clk), .reset(reset), .clr(clear),
    .inc(run_en && pkt_err), .count(err_cnt));
  csi_sat_counter #(.CNT_W(CNT_W)) u_frame (
    .csi_byte_clk(csi_byte_clk), .reset(reset), .clr(clear),
    .inc(frame_close), .count(frame_cnt));
  csi_sat_counter #(.CNT_W(CNT_W)) u_viol (
    .csi_byte_clk(csi_byte_clk), .reset(reset), .clr(clear),
    .inc(viol), .count(viol_cnt));
  csi_sat_counter #(.CNT_W(CNT_W)) u_line (
    .csi_byte_clk(csi_byte_clk), .reset(reset), .clr(clear || line_clr),
    .inc(line_inc), .count(line_cnt));
  // word_load clears and increments together, starting a line at one word.
  csi_sat_counter #(.CNT_W(CNT_W)) u_word (
    .csi_byte_clk(csi_byte_clk), .reset(reset), .clr(clear || word_load),
    .inc(word_load || word_inc), .count(word_cnt));

  always_comb begin
    case (stat_sel)
      STAT_GOOD:  sel_stat = good_cnt;
      STAT_ERR:   sel_stat = err_cnt;
      STAT_FRAME: sel_stat = frame_cnt;
      STAT_LINES: sel_stat = lines_last;
      STAT_WORDS: sel_stat = words_last;
      STAT_MAXW:  sel_stat = max_words;
      STAT_VIOL:  sel_stat = viol_cnt;
      default:    sel_stat = '0;
    endcase
    shifted = sel_stat >> {byte_sel, 3'b000};
    if (stat_sel == STAT_ID) begin
      rd_byte = ID_BYTE;
    end else if ({1'b0, byte_sel} >= NUM_BYTES) begin
      rd_byte = '0;
    end else begin
      rd_byte = shifted[7:0];
    end
  end

endmodule

// File: tb/tb_csi_stat_monitor.sv
// Directed self-checking bench for csi_stat_monitor. Drives a 16-bit and
// an 8-bit counter instance from the same stimulus.
module tb_csi_stat_monitor;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0, clear = 1'b0;
  logic       frame_start = 1'b0, frame_end = 1'b0, raw_valid = 1'b0;
  logic       pkt_good = 1'b0, pkt_err = 1'b0;
  logic [2:0] stat_sel = 3'd0;
  logic       byte_sel = 1'b0;
  logic [7:0] dbg16, dbg8;
  logic       err16, err8, fa16, fa8;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  csi_stat_monitor #(.CNT_W(16), .BYTE_SEL_W(1)) dut16 (
    .csi_byte_clk(clk), .reset(reset), .enable(enable), .clear(clear),
    .frame_start(frame_start), .frame_end(frame_end), .raw_valid(raw_valid),
    .pkt_good(pkt_good), .pkt_err(pkt_err), .stat_sel(stat_sel),
    .byte_sel(byte_sel), .dbg_byte(dbg16), .err_seen(err16),
    .frame_active(fa16));

  csi_stat_monitor #(.CNT_W(8), .BYTE_SEL_W(1)) dut8 (
    .csi_byte_clk(clk), .reset(reset), .enable(enable), .clear(clear),
    .frame_start(frame_start), .frame_end(frame_end), .raw_valid(raw_valid),
    .pkt_good(pkt_good), .pkt_err(pkt_err), .stat_sel(stat_sel),
    .byte_sel(byte_sel), .dbg_byte(dbg8), .err_seen(err8),
    .frame_active(fa8));

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic read_stat(input logic [2:0] s, input logic b);
    stat_sel = s;
    byte_sel = b;
    tick(1);
  endtask

  task automatic pulse_start();
    frame_start = 1'b1; tick(1); frame_start = 1'b0;
  endtask

  task automatic pulse_end();
    frame_end = 1'b1; tick(1); frame_end = 1'b0; tick(1);
  endtask

  task automatic pulse_clear();
    clear = 1'b1; tick(1); clear = 1'b0;
  endtask

  task automatic send_line(input int n);
    raw_valid = 1'b1; tick(n); raw_valid = 1'b0; tick(1);
  endtask

  initial begin
    #12;
    check("reset_dbg", {24'd0, dbg16}, 32'h0);
    check("reset_err", {31'd0, err16}, 32'h0);
    check("reset_fa", {31'd0, fa16}, 32'h0);
    reset = 1'b0;
    enable = 1'b1;
    tick(2);

    // Frame of 4, 6, 5 words.
    pulse_clear();
    pulse_start();
    send_line(4);
    send_line(6);
    check("fa_in_frame", {31'd0, fa16}, 32'h1);
    send_line(5);
    pulse_end();
    check("fa_after_end", {31'd0, fa16}, 32'h0);
    read_stat(3'd3, 1'b0); check("lines_last", {24'd0, dbg16}, 32'd3);
    read_stat(3'd4, 1'b0); check("words_last", {24'd0, dbg16}, 32'd5);
    read_stat(3'd5, 1'b0); check("max_words", {24'd0, dbg16}, 32'd6);
    read_stat(3'd2, 1'b0); check("frame_cnt", {24'd0, dbg16}, 32'd1);
    check("geom_err_seen", {31'd0, err16}, 32'h0);

    // Packet counters, one simultaneous pair, then clear.
    pulse_clear();
    pkt_good = 1'b1; tick(1);
    pkt_err = 1'b1; tick(1);
    pkt_good = 1'b0; pkt_err = 1'b0; tick(1);
    read_stat(3'd0, 1'b0); check("good_cnt", {24'd0, dbg16}, 32'd2);
    read_stat(3'd1, 1'b0); check("err_cnt", {24'd0, dbg16}, 32'd1);
    check("pkt_err_seen", {31'd0, err16}, 32'h1);
    pulse_clear();
    check("clear_err_seen", {31'd0, err16}, 32'h0);
    for (int s = 0; s < 7; s++) begin
      read_stat(3'(s), 1'b0);
      check($sformatf("clear_stat%0d", s), {24'd0, dbg16}, 32'h0);
    end

    // 300 pkt_good pulses: 8-bit instance saturates.
    pkt_good = 1'b1; tick(300); pkt_good = 1'b0;
    read_stat(3'd0, 1'b0);
    check("sat8_b0", {24'd0, dbg8}, 32'hFF);
    check("cnt16_b0", {24'd0, dbg16}, 32'h2C);
    read_stat(3'd0, 1'b1);
    check("cnt16_b1", {24'd0, dbg16}, 32'h01);
    check("sat8_b1_oob", {24'd0, dbg8}, 32'h00);

    // Violations: frame_end in IDLE, frame_start twice.
    pulse_clear();
    pulse_end();
    pulse_start();
    tick(1);
    pulse_start();
    pulse_end();
    read_stat(3'd6, 1'b0); check("viol_cnt", {24'd0, dbg16}, 32'd2);
    read_stat(3'd2, 1'b0); check("viol_frame_cnt", {24'd0, dbg16}, 32'd1);
    check("viol_err_seen", {31'd0, err16}, 32'h1);

    // Coincident frame_end + frame_start inside a frame: no violation.
    pulse_clear();
    pulse_start();
    send_line(2);
    frame_end = 1'b1; frame_start = 1'b1; tick(1);
    frame_end = 1'b0; frame_start = 1'b0;
    check("both_fa", {31'd0, fa16}, 32'h1);
    pulse_end();
    read_stat(3'd6, 1'b0); check("both_viol", {24'd0, dbg16}, 32'd0);
    read_stat(3'd2, 1'b0); check("both_frames", {24'd0, dbg16}, 32'd2);

    // Disabled monitor ignores events.
    pulse_clear();
    enable = 1'b0;
    pkt_good = 1'b1; tick(3); pkt_good = 1'b0;
    pulse_start();
    check("dis_fa", {31'd0, fa16}, 32'h0);
    read_stat(3'd0, 1'b0); check("dis_good", {24'd0, dbg16}, 32'd0);
    enable = 1'b1;

    // Reset mid-line.
    pulse_clear();
    stat_sel = 3'd7;
    pulse_start();
    raw_valid = 1'b1;
    tick(3);
    check("id_before_rst", {24'd0, dbg16}, 32'hC5);
    #2 reset = 1'b1;
    #1;
    check("rst_dbg", {24'd0, dbg16}, 32'h0);
    check("rst_fa", {31'd0, fa16}, 32'h0);
    raw_valid = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(1);
    pulse_start();
    send_line(2);
    send_line(3);
    pulse_end();
    read_stat(3'd3, 1'b0); check("rst_lines", {24'd0, dbg16}, 32'd2);

    // good_cnt = 0x1234, byte lanes with one-cycle latency, ID byte.
    pulse_clear();
    pkt_good = 1'b1; tick(16'h1234); pkt_good = 1'b0;
    read_stat(3'd0, 1'b0);
    check("lane0", {24'd0, dbg16}, 32'h34);
    byte_sel = 1'b1;
    #1 check("lane1_latency", {24'd0, dbg16}, 32'h34);
    tick(1);
    check("lane1", {24'd0, dbg16}, 32'h12);
    read_stat(3'd7, 1'b1); check("id_byte", {24'd0, dbg16}, 32'hC5);
    check("id_byte8", {24'd0, dbg8}, 32'hC5);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
